stream_fifo_flushable: RTL and testbench
========================================

Name: stream_fifo_flushable

Overview:
- Flushable, fixed-depth, first-word-latency-1 stream FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the flushable spill register and feeds it.
- Absorbs producer bursts while the downstream pipe stalls.
- Shares the same flush_i request, so a pipeline flush empties the FIFO and the spill register in the same cycle.
- Cuts all combinational paths input-to-output; ready_o never depends on ready_i.

Parameters:
- T, logic, payload type.
- Depth, 4, number of entries; legal range 2..1024, any integer (need not be a power of two).
- Bypass, 1'b0, when set the block is a wire: valid_o=valid_i, ready_o=ready_i, data_o=data_i; usage_o=0, full_o=0, empty_o=1.
- AddrWidth, $clog2(Depth), derived; not to be overridden.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all stored entries at next edge
- valid_i  in  1  upstream data valid
- ready_o  out  1  FIFO can accept (= !full_o)
- data_i  in  T  upstream payload
- valid_o  out  1  FIFO holds at least one entry (= !empty_o)
- ready_i  in  1  downstream ready
- data_o  out  T  head entry
- usage_o  out  AddrWidth+1  number of stored entries, 0..Depth
- full_o  out  1  usage_o==Depth
- empty_o  out  1  usage_o==0

Behaviour:
- Storage: Depth-entry register array, write pointer wr_q, read pointer rd_q, count cnt_q (AddrWidth+1 bits). All state is updated only on the rising clk_i edge.
- Reset (rst_i high at an edge): wr_q=0, rd_q=0, cnt_q=0, all storage entries '0.
  - Outputs after reset: valid_o=0, ready_o=1, data_o='0, usage_o=0, full_o=0, empty_o=1.
  - Reset overrides flush and any handshakes in the same cycle.
  - Reset mid-burst loses all contents; nothing is replayed.
- push = valid_i && ready_o && !flush_i; pop = valid_o && ready_i && !flush_i.
- Push: mem[wr_q]<=data_i; wr_q advances by 1 and wraps from Depth-1 to 0 (explicit compare, not a power-of-two mask).
- Pop: rd_q advances with the same wrap rule.
- Count update:
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop together: cnt unchanged, and the entry is written and the head read in the same cycle.
- No fall-through: a word pushed at edge N is visible on data_o/valid_o after edge N, never combinationally. Latency from empty is 1 cycle.
- Full: ready_o=0, so valid_i is ignored. A pop while full does not raise ready_o in the same cycle; it rises in the next cycle. This avoids a ready_i-to-ready_o path.
- Empty: valid_o=0; data_o is mem[rd_q] (stale, don't-care).
- data_o = mem[rd_q] at all times. It holds stable while valid_o && !ready_i (AXI-style stability). valid_o never drops without a pop or a flush.
- Flush (flush_i high at an edge, rst_i low): wr_q=0, rd_q=0, cnt_q=0. Storage is not cleared.
  - A valid_i/ready_o handshake in the flush cycle is dropped: no write, no count change.
  - A valid_o/ready_i handshake in the flush cycle completes downstream, but the FIFO treats it as part of the discard.
  - Outputs are unchanged in the flush cycle; valid_o=0 and ready_o=1 from the next cycle.
- Simulation-only assertions (excluded under SYNTHESIS / COMMON_CELLS_ASSERTS_OFF):
  - warn on flush_i && valid_i (data loss);
  - error if cnt_q>Depth;
  - error if valid_o falls without a pop or flush;
  - fatal at elaboration if Depth<2.

Test Plan:
- Reset then idle, Depth=4, T=logic[7:0] -> valid_o=0, ready_o=1, usage_o=0, empty_o=1, full_o=0, data_o=8'h00.
- Push 8'hA1,8'hA2,8'hA3,8'hA4 on consecutive cycles with ready_i=0 -> usage_o 1,2,3,4. After the 4th edge: full_o=1, ready_o=0, data_o=8'hA1. A 5th word 8'hA5 held on valid_i is not accepted.
- From full, hold ready_i=1 and valid_i=1 with 8'hA5 -> A1 pops, and ready_o rises only the following cycle. Output order is A1,A2,A3,A4,A5 with no loss or duplication. usage_o never exceeds 4.
- Continuous push and pop, 10 words 8'h10..8'h19 with ready_i=1 -> usage_o stays 1 after the first edge. Pointers wrap past entry 3 and output order is preserved.
- With 3 entries stored, assert flush_i for one cycle -> next cycle usage_o=0, valid_o=0, ready_o=1. A subsequent push of 8'h55 appears on data_o one cycle later with usage_o=1.
- Assert rst_i while 2 entries are stored and ready_i toggles -> the next cycle matches reset values. Stored data never reappears. A push of 8'h77 after rst_i falls is the first output.

Source files
------------

// File: rtl/stream_fifo_flushable.sv
// Flushable stream FIFO with valid/ready handshakes on both sides and a
// one-cycle first-word latency. It absorbs producer bursts while the
// downstream stalls. A flush_i shared with the downstream spill register
// empties both blocks in the same cycle. All input-to-output paths are
// registered, so ready_o never depends on ready_i.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous, active-high reset
//   flush_i  discard all stored entries at the next edge
//   valid_i  upstream data valid
//   ready_o  FIFO can accept a word (= !full_o)
//   data_i   upstream payload
//   valid_o  FIFO holds at least one entry (= !empty_o)
//   ready_i  downstream ready
//   data_o   head entry
//   usage_o  number of stored entries, 0..Depth
//   full_o   usage_o == Depth
//   empty_o  usage_o == 0
module stream_fifo_flushable #(
    parameter type         T         = logic,
    parameter int unsigned Depth     = 4,
    parameter bit          Bypass    = 1'b0,
    parameter int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  T                     data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output T                     data_o,
    output logic [AddrWidth:0]   usage_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned CntWidth = AddrWidth + 1;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0]  FullCnt  = CntWidth'(Depth);

    T                     mem_q [Depth];
    logic [AddrWidth-1:0] wr_q, wr_d;
    logic [AddrWidth-1:0] rd_q, rd_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_full  = (cnt_q == FullCnt);
    assign fifo_empty = (cnt_q == '0);

    // Handshakes in a flush cycle are swallowed by the discard.
    assign push = valid_i && !fifo_full && !flush_i;
    assign pop  = !fifo_empty && ready_i && !flush_i;

    // Next-state for pointers and count. Wrap uses an explicit compare so
    // non-power-of-two depths work.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                wr_d = (wr_q == LastAddr) ? '0 : wr_q + AddrWidth'(1);
            end
            if (pop) begin
                rd_d = (rd_q == LastAddr) ? '0 : rd_q + AddrWidth'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntWidth'(1);
                2'b01:   cnt_d = cnt_q - CntWidth'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

    always_comb begin
        if (Bypass) begin
            valid_o = valid_i;
            ready_o = ready_i;
            data_o  = data_i;
            usage_o = '0;
            full_o  = 1'b0;
            empty_o = 1'b1;
        end else begin
            // Head is always driven from storage; stale while empty.
            valid_o = !fifo_empty;
            ready_o = !fifo_full;
            data_o  = mem_q[rd_q];
            usage_o = cnt_q;
            full_o  = fifo_full;
            empty_o = fifo_empty;
        end
    end

`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
    if (Depth < 2) begin : gen_depth_check
        $fatal(1, "stream_fifo_flushable: Depth must be at least 2");
    end

    flush_drop_warn: assert property (@(posedge clk_i) disable iff (rst_i)
        !(flush_i && valid_i))
        else $warning("stream_fifo_flushable: valid_i dropped by flush_i");

    cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q <= FullCnt)
        else $error("stream_fifo_flushable: count exceeds Depth");

    valid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (!fifo_empty && !ready_i && !flush_i) |=> !fifo_empty)
        else $error("stream_fifo_flushable: valid_o fell without pop or flush");
`endif
`endif

endmodule

// File: tb/tb_stream_fifo_flushable.sv
module tb_stream_fifo_flushable;

    localparam int unsigned Depth = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] data_o;
    logic [2:0] usage_o;
    logic       full_o;
    logic       empty_o;

    int total  = 0;
    int bad    = 0;
    int popped = 0;
    int base;
    bit mon_en = 1'b0;

    logic [7:0] exp_q[$];

    stream_fifo_flushable #(
        .T      (logic [7:0]),
        .Depth  (Depth),
        .Bypass (1'b0)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .usage_o (usage_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: flags and usage against the queue depth, data order on pops.
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("mon_usage", usage_o, exp_q.size());
            chk("mon_valid", valid_o, exp_q.size() != 0);
            chk("mon_ready", ready_o, exp_q.size() < Depth);
            chk("mon_full", full_o, exp_q.size() == Depth);
            chk("mon_empty", empty_o, exp_q.size() == 0);
            if (rst_i || flush_i) begin
                exp_q.delete();
            end else begin
                if (valid_o && ready_i && exp_q.size() > 0) begin
                    chk("mon_data", data_o, exp_q[0]);
                    void'(exp_q.pop_front());
                    popped++;
                end
                if (valid_i && ready_o) exp_q.push_back(data_i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i   = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = 8'h00;
        step();
        step();
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // Reset values
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_usage", usage_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_data", data_o, 8'h00);

        // Fill to full with downstream stalled
        valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = 8'hA1 + 8'(i);
            step();
            chk("fill_usage", usage_o, i + 1);
        end
        chk("full_flag", full_o, 1);
        chk("full_ready", ready_o, 0);
        chk("full_head", data_o, 8'hA1);
        data_i = 8'hA5;
        step();
        step();
        chk("full_hold_usage", usage_o, 4);
        chk("full_hold_head", data_o, 8'hA1);

        // Pop from full: ready_o must not react to ready_i in the same cycle
        base    = popped;
        ready_i = 1'b1;
        #1;
        chk("no_comb_ready", ready_o, 0);
        step();
        chk("ready_late", ready_o, 1);
        chk("pop1_usage", usage_o, 3);
        chk("pop1_head", data_o, 8'hA2);
        step();
        chk("pushpop_usage", usage_o, 3);
        valid_i = 1'b0;
        drain("drain_full");
        chk("full_popped", popped - base, 5);

        // Streaming with pointer wrap
        base = popped;
        valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_i = 8'h10 + 8'(i);
            step();
            chk("stream_usage", usage_o, 1);
        end
        valid_i = 1'b0;
        drain("drain_stream");
        chk("stream_popped", popped - base, 10);

        // Flush with 3 entries stored
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_i = 8'hB0 + 8'(i);
            step();
        end
        valid_i = 1'b0;
        chk("preflush_usage", usage_o, 3);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_usage", usage_o, 0);
        chk("flush_valid", valid_o, 0);
        chk("flush_ready", ready_o, 1);
        valid_i = 1'b1;
        data_i  = 8'h55;
        step();
        valid_i = 1'b0;
        chk("postflush_valid", valid_o, 1);
        chk("postflush_data", data_o, 8'h55);
        chk("postflush_usage", usage_o, 1);
        ready_i = 1'b1;
        drain("drain_flush");

        // Reset mid-burst with ready_i toggling
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'hC0;
        step();
        data_i = 8'hC1;
        step();
        valid_i = 1'b0;
        chk("prerst_usage", usage_o, 2);
        rst_i   = 1'b1;
        ready_i = 1'b1;
        step();
        rst_i   = 1'b0;
        ready_i = 1'b0;
        chk("rst2_valid", valid_o, 0);
        chk("rst2_ready", ready_o, 1);
        chk("rst2_usage", usage_o, 0);
        chk("rst2_data", data_o, 8'h00);
        valid_i = 1'b1;
        data_i  = 8'h77;
        step();
        valid_i = 1'b0;
        chk("postrst_head", data_o, 8'h77);
        base    = popped;
        ready_i = 1'b1;
        drain("drain_rst");
        chk("postrst_popped", popped - base, 1);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
